// File: rtl/amem_pkg.sv
// amem_pkg: shared widths and state encodings for the A-memory port controller
package amem_pkg;
  localparam int AMEM_ADDR_W = 10;
  localparam int AMEM_DATA_W = 32;
  typedef enum logic {PH_RD, PH_WR} phase_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_SPY} owner_e;
endpackage

// File: rtl/amem_port_ctl_if.sv
// amem_port_ctl_if: A-memory RAM port bus (shared address, read/write enables, data)
interface amem_port_ctl_if
  import amem_pkg::*;
();
  logic [AMEM_ADDR_W-1:0] aadr;
  logic arp;
  logic awp;
  logic [AMEM_DATA_W-1:0] l;
  logic [AMEM_DATA_W-1:0] amem;
  modport master (output aadr, output arp, output awp, output l, input amem);
  modport slave (input aadr, input arp, input awp, input l, output amem);
endinterface

// File: rtl/amem_wb_buf.sv
// amem_wb_buf: one-entry write-back buffer with pending-address hit detect
module amem_wb_buf
  import amem_pkg::*;
#(
  parameter int ADDR_W = AMEM_ADDR_W,
  parameter int DATA_W = AMEM_DATA_W
) (
  input  logic clk,
  input  logic reset,
  input  logic drain,
  input  logic wb_valid,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rd_adr,
  output logic wb_ready,
  output logic pend_v,
  output logic [ADDR_W-1:0] pend_adr,
  output logic [DATA_W-1:0] pend_data,
  output logic hit
);
  logic accept;
  assign wb_ready = reset || !pend_v || drain;
  assign accept = wb_valid && wb_ready;
  assign hit = pend_v && pend_adr == rd_adr;
  // an accept during a draining clock refills the entry behind the outgoing write
  always_ff @(posedge clk) begin
    pend_v <= !reset && (accept || (pend_v && !drain));
    if (accept) begin
      pend_adr <= wb_adr;
      pend_data <= wb_data;
    end
  end
endmodule

// File: rtl/amem_port_ctl.sv
// amem_port_ctl: A-memory access controller; alternates RD/WR phases on the shared
// RAM address, buffers one write-back, forwards pending data and serves spy reads.
module amem_port_ctl
  import amem_pkg::*;
#(
  parameter int ADDR_W = AMEM_ADDR_W,
  parameter int DATA_W = AMEM_DATA_W
) (
  input  logic clk,
  input  logic reset,
  input  logic src_rd,
  input  logic [ADDR_W-1:0] src_adr,
  output logic [DATA_W-1:0] a_out,
  output logic a_valid,
  input  logic wb_valid,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [DATA_W-1:0] wb_data,
  output logic wb_ready,
  input  logic cpu_halt,
  input  logic spy_req,
  input  logic [ADDR_W-1:0] spy_adr,
  output logic [DATA_W-1:0] spy_data,
  output logic spy_ack,
  amem_port_ctl_if.master ram
);
  phase_e ph;
  owner_e own;
  logic spy_gnt, cpu_gnt, rd_en, wr_en, hit, pend_v, pass, spy_busy;
  logic [ADDR_W-1:0] rd_adr, pend_adr, aadr_q, aadr;
  logic [DATA_W-1:0] pend_data, pass_data, result, a_q, spy_q;
  amem_wb_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
    .clk(clk), .reset(reset), .drain(ph == PH_WR),
    .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data),
    .rd_adr(rd_adr), .wb_ready(wb_ready), .pend_v(pend_v),
    .pend_adr(pend_adr), .pend_data(pend_data), .hit(hit)
  );
  assign spy_gnt = !reset && ph == PH_RD && cpu_halt && spy_req && !spy_busy;
  assign cpu_gnt = !reset && ph == PH_RD && src_rd && !spy_gnt;
  assign rd_en = spy_gnt || cpu_gnt;
  assign rd_adr = spy_gnt ? spy_adr : src_adr;
  assign wr_en = !reset && ph == PH_WR && pend_v;
  always_comb begin
    aadr = reset ? '0 : rd_en ? rd_adr : wr_en ? pend_adr : aadr_q;
    ram.aadr = aadr;
    ram.arp = rd_en;
    ram.awp = wr_en;
    ram.l = wr_en ? pend_data : '0;
    result = pass ? pass_data : ram.amem;
    a_valid = !reset && ph == PH_WR && own == OWN_CPU;
    spy_ack = !reset && ph == PH_WR && own == OWN_SPY;
    a_out = a_valid ? result : a_q;
    spy_data = spy_ack ? result : spy_q;
  end
  // spy_busy stays set after the ack until spy_req is seen low, so a held request reads once
  always_ff @(posedge clk) begin
    if (reset) begin
      ph <= PH_RD;
      own <= OWN_NONE;
      pass <= 1'b0;
      spy_busy <= 1'b0;
      aadr_q <= '0;
      a_q <= '0;
      spy_q <= '0;
    end else begin
      ph <= ph == PH_RD ? PH_WR : PH_RD;
      own <= spy_gnt ? OWN_SPY : cpu_gnt ? OWN_CPU : OWN_NONE;
      pass <= rd_en && hit;
      spy_busy <= spy_gnt || (spy_busy && (spy_req || own == OWN_SPY));
      aadr_q <= aadr;
      a_q <= a_out;
      spy_q <= spy_data;
    end
    if (rd_en) pass_data <= pend_data;
  end
endmodule

// File: tb/tb_amem_port_ctl.sv
// tb_amem_port_ctl: directed checks of phasing, write-back, pass-around, spy and reset
module tb_amem_port_ctl;
  logic clk = 0;
  logic reset = 1;
  logic src_rd = 0;
  logic [9:0] src_adr = 0;
  logic [31:0] a_out;
  logic a_valid;
  logic wb_valid = 0;
  logic [9:0] wb_adr = 0;
  logic [31:0] wb_data = 0;
  logic wb_ready;
  logic cpu_halt = 0;
  logic spy_req = 0;
  logic [9:0] spy_adr = 0;
  logic [31:0] spy_data;
  logic spy_ack;
  logic pl_en = 0;
  logic [9:0] pl_adr = 0;
  logic [31:0] pl_dat = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q;
  int n_chk = 0;
  int n_pass = 0;
  amem_port_ctl_if ram();
  amem_port_ctl dut (
    .clk(clk), .reset(reset), .src_rd(src_rd), .src_adr(src_adr),
    .a_out(a_out), .a_valid(a_valid), .wb_valid(wb_valid), .wb_adr(wb_adr),
    .wb_data(wb_data), .wb_ready(wb_ready), .cpu_halt(cpu_halt),
    .spy_req(spy_req), .spy_adr(spy_adr), .spy_data(spy_data),
    .spy_ack(spy_ack), .ram(ram)
  );
  always #5 clk = ~clk;
  // RAM model: registered read, write on awp
  always @(posedge clk) begin
    if (pl_en) mem[pl_adr] <= pl_dat;
    if (ram.awp) mem[ram.aadr] <= ram.l;
    if (ram.arp) rd_q <= mem[ram.aadr];
  end
  assign ram.amem = rd_q;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en = 1; pl_adr = a; pl_dat = d;
    cyc();
    pl_en = 0;
  endtask
  initial begin
    cyc();
    preload(10'h005, 32'hDEADBEEF);
    preload(10'h010, 32'h0);
    preload(10'h020, 32'h0);
    preload(10'h3FF, 32'h0000A5A5);
    preload(10'h050, 32'h55555555);
    cyc();
    reset = 0; #1;
    chk("rst_arp", ram.arp, 0);
    chk("rst_awp", ram.awp, 0);
    chk("rst_aadr", ram.aadr, 0);
    chk("rst_l", ram.l, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_spy_ack", spy_ack, 0);
    chk("rst_wb_ready", wb_ready, 1);
    src_rd = 1; src_adr = 10'h005; #1;
    chk("rd5_arp", ram.arp, 1);
    chk("rd5_aadr", ram.aadr, 10'h005);
    cyc(); src_rd = 0; #1;
    chk("rd5_valid", a_valid, 1);
    chk("rd5_data", a_out, 32'hDEADBEEF);
    chk("wr_arp0", ram.arp, 0);
    cyc(); wb_valid = 1; wb_adr = 10'h010; wb_data = 32'h12345678; #1;
    chk("wb1_ready", wb_ready, 1);
    chk("hold_valid", a_valid, 0);
    chk("hold_a_out", a_out, 32'hDEADBEEF);
    cyc(); wb_valid = 0; #1;
    chk("wb1_awp", ram.awp, 1);
    chk("wb1_aadr", ram.aadr, 10'h010);
    chk("wb1_l", ram.l, 32'h12345678);
    cyc(); src_rd = 1; src_adr = 10'h010; #1;
    chk("wb1_drained", wb_ready, 1);
    chk("rd10_arp", ram.arp, 1);
    cyc(); src_rd = 0; #1;
    chk("rd10_valid", a_valid, 1);
    chk("rd10_data", a_out, 32'h12345678);
    wb_valid = 1; wb_adr = 10'h020; wb_data = 32'hCAFEF00D; #1;
    chk("wb2_ready_wr", wb_ready, 1);
    cyc(); wb_valid = 0; src_rd = 1; src_adr = 10'h020; #1;
    chk("wb2_ready_rd", wb_ready, 0);
    chk("pa_arp", ram.arp, 1);
    chk("pa_awp", ram.awp, 0);
    cyc(); src_rd = 0; #1;
    chk("pa_awp_wr", ram.awp, 1);
    chk("pa_aadr", ram.aadr, 10'h020);
    chk("pa_valid", a_valid, 1);
    chk("pa_data", a_out, 32'hCAFEF00D);
    cyc();
    chk("pa_ram", mem[10'h020], 32'hCAFEF00D);
    wb_valid = 1; wb_adr = 10'h030; wb_data = 32'hA1A1A1A1; #1;
    chk("b2b_ready0", wb_ready, 1);
    cyc(); wb_adr = 10'h031; wb_data = 32'hA2A2A2A2; #1;
    chk("b2b_awp0", ram.awp, 1);
    chk("b2b_aadr0", ram.aadr, 10'h030);
    chk("b2b_l0", ram.l, 32'hA1A1A1A1);
    chk("b2b_ready1", wb_ready, 1);
    cyc(); wb_adr = 10'h032; wb_data = 32'hA3A3A3A3; #1;
    chk("b2b_held", wb_ready, 0);
    chk("b2b_no_awp", ram.awp, 0);
    cyc(); #1;
    chk("b2b_awp1", ram.awp, 1);
    chk("b2b_aadr1", ram.aadr, 10'h031);
    chk("b2b_l1", ram.l, 32'hA2A2A2A2);
    chk("b2b_ready2", wb_ready, 1);
    cyc(); wb_valid = 0; #1;
    chk("b2b_held2", wb_ready, 0);
    cyc(); #1;
    chk("b2b_aadr2", ram.aadr, 10'h032);
    chk("b2b_l2", ram.l, 32'hA3A3A3A3);
    cyc();
    chk("b2b_ram0", mem[10'h030], 32'hA1A1A1A1);
    chk("b2b_ram1", mem[10'h031], 32'hA2A2A2A2);
    chk("b2b_ram2", mem[10'h032], 32'hA3A3A3A3);
    cpu_halt = 1; spy_req = 1; spy_adr = 10'h3FF; src_rd = 1; src_adr = 10'h005; #1;
    chk("spy_arp", ram.arp, 1);
    chk("spy_aadr", ram.aadr, 10'h3FF);
    cyc(); src_rd = 0; #1;
    chk("spy_ack", spy_ack, 1);
    chk("spy_data", spy_data, 32'h0000A5A5);
    chk("spy_no_valid", a_valid, 0);
    chk("spy_a_hold", a_out, 32'hCAFEF00D);
    cyc(); #1;
    chk("spy_no_regrant", ram.arp, 0);
    cyc(); #1;
    chk("spy_no_ack2", spy_ack, 0);
    chk("spy_data_hold", spy_data, 32'h0000A5A5);
    cyc(); spy_req = 0;
    cyc();
    cyc(); spy_req = 1; spy_adr = 10'h005; #1;
    chk("spy_rearm", ram.arp, 1);
    cyc(); cpu_halt = 0; #1;
    chk("spy_drop_ack", spy_ack, 1);
    chk("spy_drop_data", spy_data, 32'hDEADBEEF);
    spy_req = 0;
    cyc(); wb_valid = 1; wb_adr = 10'h050; wb_data = 32'h99999999; src_rd = 1; src_adr = 10'h005; #1;
    chk("rstwr_accept", wb_ready, 1);
    cyc(); wb_valid = 0; src_rd = 0; reset = 1; #1;
    chk("rstwr_awp", ram.awp, 0);
    chk("rstwr_valid", a_valid, 0);
    chk("rstwr_ready", wb_ready, 1);
    cyc(); reset = 0; #1;
    chk("rstwr_awp2", ram.awp, 0);
    chk("rstwr_arp2", ram.arp, 0);
    chk("rstwr_ready2", wb_ready, 1);
    cyc(); #1;
    chk("rstwr_awp3", ram.awp, 0);
    chk("rstwr_valid3", a_valid, 0);
    chk("rstwr_ack3", spy_ack, 0);
    chk("rstwr_ram", mem[10'h050], 32'h55555555);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
